mips_cpu_wb_arbiter: RTL and testbench

//   Shares the single write port of mips_cpu_regs between two writeback requesters
//   (A: ALU result path, B: load/multiply result path). Each requester has a small FIFO

---
 rtl/mips_cpu_wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mips_cpu_wb_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cpu_wb_arbiter.sv
// Writeback arbiter: two small request FIFOs drained round-robin into the single
// registered register-file write port, with pending-write hazard lookup for decode.

module mips_cpu_wb_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_reg,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W-1:0] head_reg,
    output logic [DATA_W-1:0] head_data,
    input  logic [ADDR_W-1:0] chk_reg_1,
    input  logic [ADDR_W-1:0] chk_reg_2,
    output logic              hit_1,
    output logic              hit_2
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  count;
    logic [IDX_W-1:0]  offset;
    logic              live;
    logic [ADDR_W-1:0] reg_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    assign count     = wr_ptr - rd_ptr;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign head_reg  = reg_mem[rd_ptr[IDX_W-1:0]];
    assign head_data = data_mem[rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Storage carries no reset: occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            reg_mem[wr_ptr[IDX_W-1:0]]  <= push_reg;
            data_mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // A slot counts only if it lies between the read and write pointers; stale
    // contents of already-drained slots must not raise a hazard.
    always_comb begin
        hit_1  = 1'b0;
        hit_2  = 1'b0;
        offset = '0;
        live   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offset = IDX_W'(i) - rd_ptr[IDX_W-1:0];
            live   = (PTR_W'(offset) < count);
            if (live && (reg_mem[i] == chk_reg_1)) hit_1 = 1'b1;
            if (live && (reg_mem[i] == chk_reg_2)) hit_2 = 1'b1;
        end
    end
endmodule

module mips_cpu_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              write_en,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] chk_reg_1,
    input  logic [ADDR_W-1:0] chk_reg_2,
    output logic              hazard_1,
    output logic              hazard_2,
    output logic              busy
);
    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    grant_t            last_grant, last_grant_next;
    logic              a_full, a_empty, b_full, b_empty;
    logic              a_push, b_push, a_pop, b_pop;
    logic [ADDR_W-1:0] a_head_reg, b_head_reg;
    logic [DATA_W-1:0] a_head_data, b_head_data;
    logic              a_hit_1, a_hit_2, b_hit_1, b_hit_2;

    // Ready comes only from registered occupancy, so a full FIFO never accepts
    // in the cycle it is being drained.
    assign a_ready = reset_n && !a_full;
    assign b_ready = reset_n && !b_full;
    // Writes to $0 complete the handshake but are dropped here.
    assign a_push  = a_valid && a_ready && (a_reg != '0);
    assign b_push  = b_valid && b_ready && (b_reg != '0);

    mips_cpu_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .reset_n(reset_n), .push(a_push), .push_reg(a_reg), .push_data(a_data),
        .pop(a_pop), .full(a_full), .empty(a_empty), .head_reg(a_head_reg),
        .head_data(a_head_data), .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
        .hit_1(a_hit_1), .hit_2(a_hit_2)
    );

    mips_cpu_wb_fifo #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .reset_n(reset_n), .push(b_push), .push_reg(b_reg), .push_data(b_data),
        .pop(b_pop), .full(b_full), .empty(b_empty), .head_reg(b_head_reg),
        .head_data(b_head_data), .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
        .hit_1(b_hit_1), .hit_2(b_hit_2)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) last_grant <= GRANT_B;
        else          last_grant <= last_grant_next;
    end

    always_comb begin
        a_pop           = 1'b0;
        b_pop           = 1'b0;
        last_grant_next = last_grant;
        if (!a_empty && (b_empty || last_grant == GRANT_B)) begin
            a_pop           = 1'b1;
            last_grant_next = GRANT_A;
        end else if (!b_empty) begin
            b_pop           = 1'b1;
            last_grant_next = GRANT_B;
        end
    end

    // Output stage: one popped entry per cycle; address/data hold when idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            write_en <= a_pop || b_pop;
            if (a_pop) begin
                write_reg  <= a_head_reg;
                write_data <= a_head_data;
            end else if (b_pop) begin
                write_reg  <= b_head_reg;
                write_data <= b_head_data;
            end
        end
    end

    assign hazard_1 = (chk_reg_1 != '0) &&
                      (a_hit_1 || b_hit_1 || (write_en && (write_reg == chk_reg_1)));
    assign hazard_2 = (chk_reg_2 != '0) &&
                      (a_hit_2 || b_hit_2 || (write_en && (write_reg == chk_reg_2)));
    assign busy     = !a_empty || !b_empty || write_en;
endmodule

// File: tb/tb_mips_cpu_wb_arbiter.sv
// Directed bench for mips_cpu_wb_arbiter with a behavioural register-file model.

module tb_mips_cpu_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg;
    logic [31:0] a_data, b_data;
    logic        write_en;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  chk_reg_1, chk_reg_2;
    logic        hazard_1, hazard_2, busy;

    int checks = 0;
    int errors = 0;
    int n_writes = 0;
    int n_zero = 0;
    logic [31:0] rf [32];

    always #5 clk = ~clk;

    mips_cpu_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .DEPTH(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
        .write_en(write_en), .write_reg(write_reg), .write_data(write_data),
        .chk_reg_1(chk_reg_1), .chk_reg_2(chk_reg_2),
        .hazard_1(hazard_1), .hazard_2(hazard_2), .busy(busy)
    );

    // Register file commits whatever the write port shows at the edge.
    always @(posedge clk) begin
        if (write_en) begin
            rf[write_reg] <= write_data;
            n_writes <= n_writes + 1;
            if (write_reg == 5'd0) n_zero <= n_zero + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input string tag, input logic [4:0] r, input logic [31:0] d);
        check({tag, "_en"}, 64'(write_en), 64'(1));
        check({tag, "_reg"}, 64'(write_reg), 64'(r));
        check({tag, "_data"}, 64'(write_data), 64'(d));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic drive_a(input logic v, input logic [4:0] r, input logic [31:0] d);
        a_valid = v; a_reg = r; a_data = d;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] r, input logic [31:0] d);
        b_valid = v; b_reg = r; b_data = d;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        reset_n = 1'b0;
        drive_a(1'b1, 5'd5, 32'h00008000);
        drive_b(1'b0, 5'd0, 32'h0);
        chk_reg_1 = 5'd5;
        chk_reg_2 = 5'd0;

        // Reset held with A requesting
        #2;
        check("rst_a_ready", 64'(a_ready), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));
        check("rst_write_en", 64'(write_en), 64'(0));
        check("rst_write_reg", 64'(write_reg), 64'(0));
        check("rst_write_data", 64'(write_data), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_hazard_1", 64'(hazard_1), 64'(0));
        step();
        step();
        check("rst_hold_write_en", 64'(write_en), 64'(0));
        a_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        check("rel_a_ready", 64'(a_ready), 64'(1));
        check("rel_b_ready", 64'(b_ready), 64'(1));

        // Single write latency
        drive_a(1'b1, 5'd5, 32'h00008000);
        #1;
        check("single_haz_pre", 64'(hazard_1), 64'(0));
        step();
        a_valid = 1'b0;
        check("single_lat_en", 64'(write_en), 64'(0));
        check("single_haz_q", 64'(hazard_1), 64'(1));
        check("single_busy", 64'(busy), 64'(1));
        step();
        expect_wr("single_wr", 5'd5, 32'h00008000);
        step();
        check("single_en_drop", 64'(write_en), 64'(0));
        check("single_rf5", 64'(rf[5]), 64'(32'h00008000));
        check("single_idle", 64'(busy), 64'(0));
        check("single_haz_post", 64'(hazard_1), 64'(0));

        // Conflict from reset: A wins first
        do_reset();
        drive_a(1'b1, 5'd6, 32'h000a0000);
        drive_b(1'b1, 5'd7, 32'h12345678);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        check("conf1_lat", 64'(write_en), 64'(0));
        step();
        expect_wr("conf1_first", 5'd6, 32'h000a0000);
        step();
        expect_wr("conf1_second", 5'd7, 32'h12345678);
        step();
        check("conf1_idle", 64'(write_en), 64'(0));
        check("conf1_hold_reg", 64'(write_reg), 64'(7));

        // A alone leaves last_grant=A, so the next conflict goes to B
        drive_a(1'b1, 5'd10, 32'h00000010);
        step();
        a_valid = 1'b0;
        step();
        expect_wr("a_only", 5'd10, 32'h00000010);
        drive_a(1'b1, 5'd11, 32'h00000011);
        drive_b(1'b1, 5'd12, 32'h00000012);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        expect_wr("conf2_first", 5'd12, 32'h00000012);
        step();
        expect_wr("conf2_second", 5'd11, 32'h00000011);
        step();
        check("conf2_idle", 64'(write_en), 64'(0));

        // Backpressure: both requesters streaming, last_grant=B after reset
        do_reset();
        drive_a(1'b1, 5'd13, 32'h13);
        drive_b(1'b1, 5'd16, 32'h16);
        step();
        check("bp1_a_ready", 64'(a_ready), 64'(1));
        check("bp1_b_ready", 64'(b_ready), 64'(1));
        check("bp1_en", 64'(write_en), 64'(0));
        drive_a(1'b1, 5'd14, 32'h14);
        drive_b(1'b1, 5'd17, 32'h17);
        step();
        expect_wr("bp2", 5'd13, 32'h13);
        check("bp2_a_ready", 64'(a_ready), 64'(1));
        check("bp2_b_ready", 64'(b_ready), 64'(0));
        drive_a(1'b1, 5'd15, 32'h15);
        drive_b(1'b1, 5'd18, 32'h18);
        step();
        expect_wr("bp3", 5'd16, 32'h16);
        check("bp3_a_ready", 64'(a_ready), 64'(0));
        check("bp3_b_ready", 64'(b_ready), 64'(1));
        a_valid = 1'b0;
        step();
        expect_wr("bp4", 5'd14, 32'h14);
        check("bp4_a_ready", 64'(a_ready), 64'(1));
        check("bp4_b_ready", 64'(b_ready), 64'(0));
        b_valid = 1'b0;
        step();
        expect_wr("bp5", 5'd17, 32'h17);
        chk_reg_1 = 5'd18;
        chk_reg_2 = 5'd17;
        #1;
        check("bp5_haz_out", 64'(hazard_2), 64'(1));
        step();
        expect_wr("bp6", 5'd15, 32'h15);
        check("bp6_haz_pending", 64'(hazard_1), 64'(1));
        check("bp6_haz_stale", 64'(hazard_2), 64'(0));
        step();
        expect_wr("bp7", 5'd18, 32'h18);
        step();
        check("bp_idle_en", 64'(write_en), 64'(0));
        check("bp_idle_busy", 64'(busy), 64'(0));

        // $0 write handshakes but is dropped
        drive_b(1'b1, 5'd0, 32'hffffffff);
        #1;
        check("zero_b_ready", 64'(b_ready), 64'(1));
        step();
        b_valid = 1'b0;
        check("zero_en1", 64'(write_en), 64'(0));
        check("zero_busy", 64'(busy), 64'(0));
        step();
        check("zero_en2", 64'(write_en), 64'(0));

        // Hazard lifetime of a pending A write
        drive_a(1'b1, 5'd9, 32'h00009999);
        chk_reg_1 = 5'd9;
        chk_reg_2 = 5'd0;
        #1;
        check("haz_pre", 64'(hazard_1), 64'(0));
        step();
        a_valid = 1'b0;
        check("haz_queued", 64'(hazard_1), 64'(1));
        check("haz_chk0", 64'(hazard_2), 64'(0));
        step();
        expect_wr("haz_wr", 5'd9, 32'h00009999);
        check("haz_on_port", 64'(hazard_1), 64'(1));
        step();
        check("haz_cleared", 64'(hazard_1), 64'(0));
        check("haz_rf9", 64'(rf[9]), 64'(32'h00009999));

        // Reset mid-operation discards everything
        drive_a(1'b1, 5'd20, 32'h20);
        drive_b(1'b1, 5'd21, 32'h21);
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        check("mid_busy", 64'(busy), 64'(1));
        step();
        expect_wr("mid_wr", 5'd21, 32'h21);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_en_drop", 64'(write_en), 64'(0));
        check("mid_busy_drop", 64'(busy), 64'(0));
        check("mid_a_ready", 64'(a_ready), 64'(0));
        #1;
        reset_n = 1'b1;
        step();
        check("mid_en_after1", 64'(write_en), 64'(0));
        step();
        check("mid_en_after2", 64'(write_en), 64'(0));
        check("mid_busy_after", 64'(busy), 64'(0));
        check("mid_rf20", 64'(rf[20]), 64'(0));
        check("mid_rf21", 64'(rf[21]), 64'(0));

        check("total_writes", 64'(n_writes), 64'(13));
        check("zero_writes", 64'(n_zero), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
